// File: rtl/cim_ctrl.sv
// Controller for a compute-in-memory macro: sequences column CIM ops through a
// 2-entry result FIFO with credit-based issue, and arbitrates host memory access.
module cim_ctrl #(
    parameter int ADDR_WIDTH             = 10,
    parameter int DATA_WIDTH             = 8,
    parameter int ADC_PRECISION          = 6,
    parameter int CIM_INPUT_PRECISION    = 4,
    parameter int CIM_OUTPUT_PARALLELISM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            cfg_bank,
    input  logic [1:0]            cfg_ncol,
    input  logic [4*CIM_INPUT_PRECISION-1:0] cfg_vec,
    output logic                  busy,
    output logic                  done,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_gnt,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CIM_OUTPUT_PARALLELISM*ADC_PRECISION-1:0] res_data,
    output logic [1:0]            res_col,
    output logic                  res_last,
    output logic                  cim_cs,
    output logic                  cim_web,
    output logic                  cim_cimeb,
    output logic [ADDR_WIDTH-1:0] cim_a,
    output logic [DATA_WIDTH-1:0] cim_d,
    output logic [4*CIM_INPUT_PRECISION-1:0] cim_in,
    input  logic [DATA_WIDTH-1:0] cim_q,
    input  logic [CIM_OUTPUT_PARALLELISM*ADC_PRECISION-1:0] cim_out
);

    localparam int VEC_W = 4 * CIM_INPUT_PRECISION;
    localparam int OUT_W = CIM_OUTPUT_PARALLELISM * ADC_PRECISION;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                r_state, w_next;
    logic [2:0]            r_bank;
    logic [1:0]            r_ncol, r_col;
    logic [VEC_W-1:0]      r_vec;
    logic                  r_if_vld, r_if_last;
    logic [1:0]            r_if_col;
    logic [OUT_W-1:0]      r_fifo_data [2];
    logic [1:0]            r_fifo_col  [2];
    logic                  r_fifo_last [2];
    logic                  r_rd_ptr, r_wr_ptr;
    logic [1:0]            r_cnt;
    logic                  r_rd_pend;
    logic [DATA_WIDTH-1:0] r_rdata_hold;

    logic                  w_pop, w_issue, w_grant, w_head_last;
    logic [2:0]            w_used;

    assign res_valid   = (r_cnt != 2'd0);
    assign w_pop       = res_valid && res_ready;
    assign w_head_last = r_fifo_last[r_rd_ptr];
    // Results about to leave this cycle free their slot, keeping one op per cycle.
    assign w_used      = {1'b0, r_cnt} + {2'b00, r_if_vld} - {2'b00, w_pop};
    assign w_issue     = (r_state == ISSUE) && (w_used < 3'd2);
    assign w_grant     = rst_n && (r_state == IDLE) && mem_req && !start;

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign mem_gnt    = w_grant;
    assign mem_rvalid = r_rd_pend;
    assign mem_rdata  = r_rd_pend ? cim_q : r_rdata_hold;
    assign res_data   = res_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign res_col    = res_valid ? r_fifo_col[r_rd_ptr] : 2'd0;
    assign res_last   = res_valid && w_head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cim_cs    = 1'b0;
        cim_web   = 1'b1;
        cim_cimeb = 1'b1;
        cim_a     = '0;
        cim_d     = '0;
        cim_in    = '0;
        case (r_state)
            IDLE:    if (start) w_next = ISSUE;
            ISSUE:   if (w_issue && (r_col == r_ncol)) w_next = DRAIN;
            DRAIN:   if (w_pop && w_head_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_issue) begin
            cim_cs    = 1'b1;
            cim_cimeb = 1'b0;
            cim_a     = ADDR_WIDTH'({r_bank, 3'b000, r_col});
            cim_in    = r_vec;
        end else if (w_grant) begin
            cim_cs  = 1'b1;
            cim_web = !mem_we;
            cim_a   = mem_addr;
            cim_d   = mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank    <= 3'd0;
            r_ncol    <= 2'd0;
            r_col     <= 2'd0;
            r_vec     <= '0;
            r_if_vld  <= 1'b0;
            r_if_col  <= 2'd0;
            r_if_last <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_bank <= cfg_bank;
                r_ncol <= cfg_ncol;
                r_vec  <= cfg_vec;
                r_col  <= 2'd0;
            end else if (w_issue) begin
                r_col <= r_col + 2'd1;
            end
            r_if_vld  <= w_issue;
            r_if_col  <= r_col;
            r_if_last <= (r_col == r_ncol);
        end
    end

    // The macro presents cim_out the cycle after an op issues; capture it then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_col[0]  <= 2'd0;
            r_fifo_col[1]  <= 2'd0;
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_cnt          <= 2'd0;
        end else begin
            if (r_if_vld) begin
                r_fifo_data[r_wr_ptr] <= cim_out;
                r_fifo_col[r_wr_ptr]  <= r_if_col;
                r_fifo_last[r_wr_ptr] <= r_if_last;
                r_wr_ptr              <= !r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= !r_rd_ptr;
            r_cnt <= r_cnt + {1'b0, r_if_vld} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend    <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rd_pend <= w_grant && !mem_we;
            if (r_rd_pend) r_rdata_hold <= cim_q;
        end
    end

endmodule

// File: tb/tb_cim_ctrl.sv
// Directed bench for cim_ctrl with a behavioural macro model that echoes
// address and inputs back as CIM output so each beat is identifiable.
module tb_cim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_req, mem_we, res_ready;
  logic [2:0]  cfg_bank;
  logic [1:0]  cfg_ncol;
  logic [15:0] cfg_vec;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy, done, mem_gnt, mem_rvalid, res_valid, res_last;
  logic [7:0]  mem_rdata;
  logic [47:0] res_data;
  logic [1:0]  res_col;
  logic        cim_cs, cim_web, cim_cimeb;
  logic [9:0]  cim_a;
  logic [7:0]  cim_d;
  logic [15:0] cim_in;
  logic [7:0]  cim_q = 8'd0;
  logic [47:0] cim_out = 48'd0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [47:0] exp_q[$];
  logic [7:0]  mem_model [1024];

  always #5 clk = ~clk;

  cim_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_bank(cfg_bank), .cfg_ncol(cfg_ncol),
    .cfg_vec(cfg_vec), .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_col(res_col), .res_last(res_last), .cim_cs(cim_cs),
    .cim_web(cim_web), .cim_cimeb(cim_cimeb), .cim_a(cim_a), .cim_d(cim_d),
    .cim_in(cim_in), .cim_q(cim_q), .cim_out(cim_out)
  );

  // Synchronous macro: memory mode and CIM mode both answer one cycle later.
  always @(posedge clk) begin
    if (cim_cs && cim_cimeb) begin
      if (!cim_web) mem_model[cim_a] <= cim_d;
      else          cim_q <= mem_model[cim_a];
    end
    if (cim_cs && !cim_cimeb) cim_out <= {cim_in, cim_in, 6'd0, cim_a};
  end

  function automatic logic [47:0] beat_of(input logic [2:0] bank, input logic [1:0] col,
                                          input logic [15:0] vec);
    logic [9:0] a;
    a = {2'b00, bank, 3'b000, col};
    return {vec, vec, 6'd0, a};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; start = 0; mem_req = 0; mem_we = 0; res_ready = 0;
    cfg_bank = 0; cfg_ncol = 0; cfg_vec = 0; mem_addr = 0; mem_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, mem_gnt, mem_rvalid, res_valid, res_last, cim_cs, cim_web, cim_cimeb} !== 9'b0000000_11) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000011",
        {busy, done, mem_gnt, mem_rvalid, res_valid, res_last, cim_cs, cim_web, cim_cimeb});
    end
    n_cmp++;
    if ({cim_a, cim_d, cim_in, res_data, res_col, mem_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {cim_a, cim_d, cim_in, res_data, res_col, mem_rdata});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, res_valid, cim_cs} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 000", {busy, res_valid, cim_cs});
    end
  endtask

  task automatic test_mem;
    @(negedge clk); mem_req = 1; mem_we = 1; mem_addr = 10'h020; mem_wdata = 8'h05; #1;
    n_cmp++;
    if ({mem_gnt, cim_cs, cim_web, cim_cimeb, cim_a, cim_d} !== {4'b1101, 10'h020, 8'h05}) begin
      n_fail++; $display("FAIL mem_write_drive: got %h want %h",
        {mem_gnt, cim_cs, cim_web, cim_cimeb, cim_a, cim_d}, {4'b1101, 10'h020, 8'h05});
    end
    @(negedge clk); mem_we = 0; #1;
    n_cmp++;
    if ({mem_gnt, cim_web, mem_rvalid} !== 3'b110) begin
      n_fail++; $display("FAIL mem_read_grant: got %b want 110", {mem_gnt, cim_web, mem_rvalid});
    end
    @(negedge clk); mem_we = 1; mem_addr = 10'h021; mem_wdata = 8'h3A; #1;
    n_cmp++;
    if ({mem_gnt, mem_rvalid, mem_rdata} !== {2'b11, 8'h05}) begin
      n_fail++; $display("FAIL mem_read_data: got %h want %h", {mem_gnt, mem_rvalid, mem_rdata}, {2'b11, 8'h05});
    end
    @(negedge clk); mem_we = 0; #1;
    n_cmp++;
    if ({mem_gnt, mem_rvalid, mem_rdata} !== {2'b10, 8'h05}) begin
      n_fail++; $display("FAIL mem_write_no_rvalid: got %h want %h", {mem_gnt, mem_rvalid, mem_rdata}, {2'b10, 8'h05});
    end
    @(negedge clk); mem_req = 0; #1;
    n_cmp++;
    if ({mem_rvalid, mem_rdata} !== {1'b1, 8'h3A}) begin
      n_fail++; $display("FAIL mem_b2b_read: got %h want %h", {mem_rvalid, mem_rdata}, {1'b1, 8'h3A});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_gnt, mem_rvalid, mem_rdata, cim_cs} !== {2'b00, 8'h3A, 1'b0}) begin
      n_fail++; $display("FAIL mem_rdata_hold: got %h want %h", {mem_gnt, mem_rvalid, mem_rdata, cim_cs}, {2'b00, 8'h3A, 1'b0});
    end
  endtask

  task automatic test_job(input logic [2:0] bank, input logic [1:0] ncol, input logic [15:0] vec,
                          input int stall, input bit restart);
    int issued, beats, last_cyc, done_cyc, first_beat;
    logic [47:0] held, e;
    bit held_v, done_seen;
    issued = 0; beats = 0; last_cyc = -1; done_cyc = -1; first_beat = -1;
    held = '0; held_v = 0; done_seen = 0;
    for (int c = 0; c <= int'(ncol); c++) exp_q.push_back(beat_of(bank, 2'(c), vec));
    @(negedge clk);
    cfg_bank = bank; cfg_ncol = ncol; cfg_vec = vec; start = 1; res_ready = (stall == 0);
    for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
      @(negedge clk);
      start = restart && (cyc == 2);
      cfg_bank = (restart && cyc == 2) ? 3'd7 : bank;
      res_ready = (cyc > stall);
      #1;
      if (cim_cs && !cim_cimeb) begin
        n_cmp++;
        if ({cim_a, cim_in} !== {2'b00, bank, 3'b000, 2'(issued), vec}) begin
          n_fail++; $display("FAIL issue_addr: got %h/%h want %h/%h", cim_a, cim_in,
            {2'b00, bank, 3'b000, 2'(issued)}, vec);
        end
        if (stall == 0) begin
          n_cmp++;
          if (cyc != issued + 1) begin
            n_fail++; $display("FAIL issue_cycle: got %0d want %0d", cyc, issued + 1);
          end
        end
        issued++;
      end
      if (stall > 0 && cyc == stall) begin
        n_cmp++;
        if (issued != 2) begin
          n_fail++; $display("FAIL credit_limit: got %0d ops want 2", issued);
        end
      end
      if (res_valid && !res_ready) begin
        if (held_v) begin
          n_cmp++;
          if (res_data !== held) begin
            n_fail++; $display("FAIL stall_stable: got %h want %h", res_data, held);
          end
        end
        held = res_data; held_v = 1;
      end else begin
        held_v = 0;
      end
      if (res_valid && res_ready) begin
        if (first_beat < 0) first_beat = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_beat: got col %0d want none", res_col);
        end else begin
          e = exp_q.pop_front();
          if ({res_data, res_col, res_last} !== {e, 2'(beats), beats == int'(ncol)}) begin
            n_fail++; $display("FAIL beat: got %h/%0d/%b want %h/%0d/%b", res_data, res_col,
              res_last, e, beats, beats == int'(ncol));
          end
        end
        beats++;
        if (res_last) last_cyc = cyc;
      end
      if (done) begin done_seen = 1; done_cyc = cyc; end
    end
    n_cmp++;
    if (!done_seen || done_cyc != last_cyc + 1) begin
      n_fail++; $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_cyc + 1);
    end
    n_cmp++;
    if (issued != int'(ncol) + 1 || beats != int'(ncol) + 1) begin
      n_fail++; $display("FAIL beat_count: got %0d ops %0d beats want %0d", issued, beats, int'(ncol) + 1);
    end
    if (stall == 0) begin
      n_cmp++;
      if (first_beat != 3) begin
        n_fail++; $display("FAIL latency: got first beat at %0d want 3", first_beat);
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, done, res_valid} !== 3'b000) begin
      n_fail++; $display("FAIL job_end_idle: got %b want 000", {busy, done, res_valid});
    end
    exp_q.delete();
  endtask

  task automatic test_start_vs_mem;
    int beats;
    bit done_seen;
    beats = 0; done_seen = 0;
    @(negedge clk);
    cfg_bank = 3'd2; cfg_ncol = 2'd1; cfg_vec = 16'h1234; start = 1; res_ready = 1;
    mem_req = 1; mem_we = 0; mem_addr = 10'h020; #1;
    n_cmp++;
    if ({mem_gnt, cim_cs} !== 2'b00) begin
      n_fail++; $display("FAIL start_priority: got %b want 00", {mem_gnt, cim_cs});
    end
    for (int cyc = 1; cyc <= 40 && !done_seen; cyc++) begin
      @(negedge clk); start = 0; #1;
      n_cmp++;
      if (mem_gnt !== 1'b0) begin
        n_fail++; $display("FAIL gnt_while_busy: got %b want 0 at cycle %0d", mem_gnt, cyc);
      end
      if (res_valid && res_ready) beats++;
      if (done) done_seen = 1;
    end
    n_cmp++;
    if (!done_seen || beats != 2) begin
      n_fail++; $display("FAIL arb_job: got done %b beats %0d want 1/2", done_seen, beats);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_gnt, cim_cs, cim_web, cim_cimeb, cim_a} !== {4'b1111, 10'h020}) begin
      n_fail++; $display("FAIL gnt_after_done: got %h want %h", {mem_gnt, cim_cs, cim_web, cim_cimeb, cim_a}, {4'b1111, 10'h020});
    end
    @(negedge clk); mem_req = 0; #1;
    n_cmp++;
    if ({mem_rvalid, mem_rdata} !== {1'b1, 8'h05}) begin
      n_fail++; $display("FAIL read_after_job: got %h want %h", {mem_rvalid, mem_rdata}, {1'b1, 8'h05});
    end
  endtask

  task automatic test_reset_mid_job;
    @(negedge clk);
    cfg_bank = 3'd1; cfg_ncol = 2'd3; cfg_vec = 16'hFFFF; start = 1; res_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk); rst_n = 0; #1;
    n_cmp++;
    if ({busy, done, mem_gnt, mem_rvalid, res_valid, res_last, cim_cs, cim_web, cim_cimeb} !== 9'b0000000_11) begin
      n_fail++; $display("FAIL midjob_reset_ctrl: got %b want 000000011",
        {busy, done, mem_gnt, mem_rvalid, res_valid, res_last, cim_cs, cim_web, cim_cimeb});
    end
    n_cmp++;
    if ({cim_a, cim_d, cim_in, res_data, res_col, mem_rdata} !== '0) begin
      n_fail++; $display("FAIL midjob_reset_data: got %h want 0", {cim_a, cim_d, cim_in, res_data, res_col, mem_rdata});
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({busy, res_valid, cim_cs} !== 3'b000) begin
        n_fail++; $display("FAIL post_reset_quiet: got %b want 000 at cycle %0d", {busy, res_valid, cim_cs}, cyc);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mem;
    test_job(3'd3, 2'd3, 16'hA5C3, 0, 1'b0);
    test_job(3'd3, 2'd3, 16'h5A3C, 10, 1'b0);
    test_start_vs_mem;
    test_reset_mid_job;
    test_job(3'd5, 2'd0, 16'h0F1E, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
